// File: rtl/mux_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux_rr_arbiter
//
// Selects one of N_CH valid/ready input channels and forwards its word through
// a single registered output stage. The selection policy is either fixed
// priority (MODE = 0, lowest index wins) or round-robin (MODE = 1, scanning
// starts at a pointer that moves to one past the last granted channel).
//
// The output stage is a one-entry pipeline register. It accepts a new word
// whenever it is empty or being drained in the same cycle, so back-to-back
// transfers run at one word per clock.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_data    in   N_CH*WIDTH packed channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid   in   N_CH per-channel valid
//   in_ready   out  N_CH per-channel ready, one-hot or zero
//   out_data   out  WIDTH registered data of the granted channel
//   out_sel    out  SELW index of the channel that supplied out_data
//   out_valid  out  registered output valid
//   out_ready  in   downstream ready
// ----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  parameter  int MODE  = 1,
  localparam int SELW  = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SELW-1:0]         out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  // --------------------------------------------------------------------------
  // Grant computation
  // --------------------------------------------------------------------------
  logic             accept;
  logic             xfer;
  logic [SELW-1:0]  scan_base;
  logic [N_CH-1:0]  upper_mask;
  logic [N_CH-1:0]  upper_req;
  logic [N_CH-1:0]  pick_req;
  logic [N_CH-1:0]  grant_oh;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;

  // The output register can take a word when it is empty or emptying now.
  assign accept = !out_valid_q || out_ready;

  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    scan_base  = (MODE == 1) ? ptr_q : '0;
    upper_mask = '0;
    grant_oh   = '0;
    grant_idx  = '0;
    grant_data = '0;

    // Round-robin as a two-pass priority search: channels at or above the
    // pointer are tried first; if none of them is valid, the search wraps to
    // the full request vector, whose lowest set bit is then below the pointer.
    for (int j = 0; j < N_CH; j++) begin
      upper_mask[j] = (j >= int'(scan_base));
    end
    upper_req = in_valid & upper_mask;
    pick_req  = (|upper_req) ? upper_req : in_valid;

    // Descending scan so the lowest set bit is the last one written.
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (pick_req[j]) begin
        grant_oh    = '0;
        grant_oh[j] = 1'b1;
        grant_idx   = SELW'(j);
        grant_data  = in_data[j*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = accept ? grant_oh : '0;
  assign xfer     = accept && (|in_valid);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;

    if (xfer) begin
      // Load and drain may coincide: the new word replaces the departing one.
      out_data_d  = grant_data;
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      if (MODE == 1) begin
        // Explicit wrap keeps ptr inside 0..N_CH-1 for non-power-of-two N_CH.
        ptr_d = (grant_idx == SELW'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      // Drained with nothing to replace it; data and index are left as-is.
      out_valid_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux_rr_arbiter
//
// Three instances share one clock and reset:
//   dut    N_CH=4, WIDTH=8, MODE=1  fully modelled, scoreboard on outputs
//   dut_fp N_CH=4, WIDTH=8, MODE=0  same inputs as dut, fixed-priority grant
//   dut3   N_CH=3, WIDTH=8, MODE=1  non-power-of-two wrap
// Inputs change on the falling edge; outputs are compared shortly after it,
// well before the next rising edge.
// ----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  logic        clk;
  logic        rst_n;

  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;

  logic [3:0]  fp_in_ready;
  logic [7:0]  fp_out_data;
  logic [1:0]  fp_out_sel;
  logic        fp_out_valid;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic        out_ready3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_valid3;

  mux_rr_arbiter #(.N_CH(4), .WIDTH(8), .MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_rr_arbiter #(.N_CH(4), .WIDTH(8), .MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(fp_in_ready), .out_data(fp_out_data), .out_sel(fp_out_sel),
    .out_valid(fp_out_valid), .out_ready(out_ready)
  );

  mux_rr_arbiter #(.N_CH(3), .WIDTH(8), .MODE(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_sel(out_sel3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Checking infrastructure and reference model of the MODE=1 instance
  // --------------------------------------------------------------------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [9:0] sb_q[$];      // expected {out_sel, out_data}, oldest first
  int         ptr_m;
  bit         valid_m;
  int         wait_cnt[4];
  logic [3:0] last_grant;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] model_grant(input logic [3:0] v, input int base);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (base + i) % 4;
      if (v[k]) return 4'(1 << k);
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    ptr_m   = 0;
    valid_m = 1'b0;
    sb_q.delete();
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
  endtask

  // One clock cycle: compare, advance the model, move to the next falling edge.
  task automatic step();
    logic [3:0] exp_rdy;
    bit         accept_m;
    int         g;
    #1;
    check("out_valid", 64'(out_valid), 64'(valid_m));
    if (valid_m && sb_q.size() > 0) begin
      check("out_word", {out_sel, out_data}, sb_q[0]);
      if (out_ready) void'(sb_q.pop_front());
    end

    accept_m = !valid_m || out_ready;
    exp_rdy  = accept_m ? model_grant(in_valid, ptr_m) : 4'b0000;
    check("in_ready", in_ready, exp_rdy);
    if (out_ready) check("fp_in_ready", fp_in_ready, model_grant(in_valid, 0));
    last_grant = in_ready;

    // Starvation bound on the observed grants.
    if (in_ready != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        if (in_ready[k]) begin
          check("rr_wait_bound", 64'(wait_cnt[k] <= 3), 64'd1);
          wait_cnt[k] = 0;
        end else if (in_valid[k]) begin
          wait_cnt[k]++;
        end else begin
          wait_cnt[k] = 0;
        end
      end
    end
    for (int k = 0; k < 4; k++) if (!in_valid[k]) wait_cnt[k] = 0;

    if (exp_rdy != 4'b0000) begin
      g = 0;
      for (int k = 0; k < 4; k++) if (exp_rdy[k]) g = k;
      sb_q.push_back({2'(g), in_data[g*8 +: 8]});
      ptr_m   = (g + 1) % 4;
      valid_m = 1'b1;
    end else if (out_ready) begin
      valid_m = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence followed by a randomised run
  // --------------------------------------------------------------------------
  initial begin
    logic [2:0] exp3 [4];
    exp3 = '{3'b001, 3'b010, 3'b100, 3'b001};

    rst_n      = 1'b0;
    in_data    = '0;
    in_valid   = '0;
    out_ready  = 1'b0;
    in_data3   = '0;
    in_valid3  = '0;
    out_ready3 = 1'b0;
    last_grant = '0;
    model_reset();

    // Reset state
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_sel",   64'(out_sel),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // All channels valid, downstream always ready: 0,1,2,3,0,... with no bubble.
    // The fixed-priority instance must keep picking channel 0.
    in_data   = 32'hA3A2A1A0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        check("fp_out_sel",   64'(fp_out_sel),   64'd0);
        check("fp_out_data",  64'(fp_out_data),  64'hA0);
        check("fp_out_valid", 64'(fp_out_valid), 64'd1);
      end
      step();
    end

    // Back-pressure for three cycles with channels 1 and 2 pending; the held
    // word must stay put, then channel 1 and channel 2 are granted in turn.
    in_valid  = 4'b0110;
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    step();
    in_valid  = 4'b0100;
    step();

    // Idle: nothing valid, output drains, pointer holds.
    in_valid = 4'b0000;
    repeat (3) step();

    // Asynchronous reset between edges while a word is held.
    in_valid = 4'b1111;
    step();
    in_valid = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_data",  64'(out_data),  64'd0);
    check("arst_out_sel",   64'(out_sel),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    in_valid = 4'b1010;
    step();
    check("post_rst_sel", 64'(out_sel), 64'd1);
    in_valid = 4'b0000;
    repeat (2) step();

    // Three-channel instance: only channel 2 valid, then all valid (wrap 2 -> 0).
    in_data3   = 24'hC2C1C0;
    out_ready3 = 1'b1;
    in_valid3  = 3'b100;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("n3_in_ready_ch2", 64'(in_ready3), 64'b100);
      if (i > 0) begin
        check("n3_out_sel",   64'(out_sel3),   64'd2);
        check("n3_out_valid", 64'(out_valid3), 64'd1);
      end
      step();
    end
    in_valid3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("n3_in_ready_wrap", 64'(in_ready3), 64'(exp3[i]));
      check("n3_sel_range",     64'(out_sel3 < 2'd3), 64'd1);
      step();
    end
    in_valid3 = 3'b000;

    // Randomised traffic: channels hold valid until granted, occasionally drop.
    for (int i = 0; i < 400; i++) begin
      in_valid = (in_valid & ~last_grant) | 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) in_valid[$urandom_range(0, 3)] = 1'b0;
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    // Drain everything that was accepted.
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    repeat (3) step();
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
